// File: rtl/serial_full_subtractor_using_multiplexer8x1.sv
// Bit-serial a - b - bin, LSB first, one 8:1-mux full-subtractor cell plus borrow flop.
// Optional signed overflow flag enabled by defining SIGNED_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; result registers hold last completion
// SHIFT | one operand bit processed per cycle, WIDTH cycles total
module serial_full_subtractor_using_multiplexer8x1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  // Cell truth tables indexed by {a_bit, b_bit, borrow}
  localparam logic [7:0] D_TBL  = 8'b1001_0110;
  localparam logic [7:0] BN_TBL = 8'b1000_1110;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic [2:0]       cell_idx;
  logic             d_bit, bn_bit;

  assign cell_idx = {sa_q[0], sb_q[0], br_q};
  assign d_bit    = D_TBL[cell_idx];
  assign bn_bit   = BN_TBL[cell_idx];

`ifdef SIGNED_OVF_EN
  logic am_q, am_d, bm_q, bm_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SIGNED_OVF_EN
    am_d    = am_q;
    bm_d    = bm_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SIGNED_OVF_EN
          am_d    = a[WIDTH-1];
          bm_d    = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        sr_d  = {d_bit, sr_q[WIDTH-2:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = bn_bit;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          diff_d  = {d_bit, sr_q};
          bout_d  = bn_bit;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef SIGNED_OVF_EN
          ovf_d   = (am_q ^ bm_q) & (am_q ^ d_bit);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
`ifdef SIGNED_OVF_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SIGNED_OVF_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_full_subtractor_using_multiplexer8x1.sv
// Bench for the bit-serial subtractor: directed cases, reset abort, back-to-back and random ops
// against an integer-arithmetic reference model.
module tb_serial_full_subtractor_using_multiplexer8x1;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout, overflow;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  serial_full_subtractor_using_multiplexer8x1 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, unsigned for diff/bout, signed range for overflow
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic rbin);
    int u, s;
    logic ovf;
    u = int'(ra) - int'(rb) - int'(rbin);
    s = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
`ifdef SIGNED_OVF_EN
    ovf = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
`else
    ovf = 1'b0;
`endif
    return {ovf, (u < 0), W'(u & ((1 << W) - 1))};
  endfunction

  // Call off-edge; start is captured at the next posedge, returns #1 after it.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done with a cycle budget; scrambles operands meanwhile; optional stray start.
  task automatic wait_done(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tbin, input bit stray_start);
    int cyc = 0;
    bit busy_bad = 0;
    logic [W+1:0] exp;
    exp = ref_sub(ta, tb_v, tbin);
    if (busy !== 1'b1) busy_bad = 1;
    for (int i = 1; i <= W + 6; i++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      start = (stray_start && i == 3);
      @(posedge clk); #1;
      cyc = i;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_bad = 1;
    end
    start = 1'b0;
    check({tag, "_latency"}, cyc, W);
    check({tag, "_busy"}, busy_bad, 0);
    check({tag, "_diff"}, diff, exp[W-1:0]);
    check({tag, "_bout"}, bout, exp[W]);
    check({tag, "_ovf"}, overflow, exp[W+1]);
  endtask

  task automatic full_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tbin);
    logic [W-1:0] held;
    @(negedge clk);
    issue(ta, tb_v, tbin);
    wait_done(tag, ta, tb_v, tbin, 0);
    held = diff;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold"}, diff, held);
  endtask

  initial begin
    int dones;
    logic [W-1:0] ra, rb;
    logic rbin;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk) rst_n = 1'b1;

    full_op("t1", 8'h5A, 8'h3C, 1'b0);
    check("t1_const", diff, 8'h1E);
    full_op("t2", 8'h00, 8'h01, 1'b0);
    check("t2_const", {bout, diff}, 9'h1FF);
    full_op("t3", 8'h10, 8'h0F, 1'b1);
    check("t3_const", {bout, diff}, 9'h000);

    // stray start during SHIFT must be ignored
    @(negedge clk);
    issue(8'hC3, 8'h47, 1'b1);
    wait_done("t4", 8'hC3, 8'h47, 1'b1, 1);
    @(posedge clk); #1;
    check("t4_idle_after", busy, 0);

    // reset mid-operation aborts without a done pulse
    full_op("t5pre", 8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    issue(8'h33, 8'h11, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("t5_busy", busy, 0);
    check("t5_diff", diff, 0);
    check("t5_bout", bout, 0);
    check("t5_done", done, 0);
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    check("t5_no_done", dones, 0);
    full_op("t5post", 8'h33, 8'h11, 1'b0);

`ifdef SIGNED_OVF_EN
    full_op("t6a", 8'h80, 8'h01, 1'b0);
    check("t6a_const", {overflow, diff}, 9'h17F);
    full_op("t6b", 8'h05, 8'h03, 1'b0);
    check("t6b_const", overflow, 0);
`endif

    // back-to-back: start held in the done cycle is accepted
    @(negedge clk);
    issue(8'hA5, 8'h5A, 1'b0);
    wait_done("b2b1", 8'hA5, 8'h5A, 1'b0, 0);
    issue(8'h01, 8'hFE, 1'b1);
    check("b2b_accept", busy, 1);
    wait_done("b2b2", 8'h01, 8'hFE, 1'b1, 0);

    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      if (n == 0) begin ra = 8'h00; rb = 8'hFF; rbin = 1'b1; end
      if (n == 1) begin ra = 8'hFF; rb = 8'h00; rbin = 1'b0; end
      full_op("rnd", ra, rb, rbin);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
